// File: rtl/input_buffer_if.sv
// Flit push/pop bundle between the upstream output controller, the input
// buffer and the routing/crossbar stage.
interface input_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  write;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  full;
  logic                  empty;
  logic                  read;
  logic [DATA_WIDTH-1:0] data_out;
  logic [CNT_W-1:0]      count;
  logic                  pkt_active;
  logic                  overflow;
  logic                  underflow;
  logic                  protocol_err;

  modport master (
    output write, data_in, read,
    input  full, empty, data_out, count, pkt_active,
           overflow, underflow, protocol_err
  );

  modport slave (
    input  write, data_in, read,
    output full, empty, data_out, count, pkt_active,
           overflow, underflow, protocol_err
  );
endinterface

// File: rtl/input_buffer.sv
// Per-port first-word-fall-through flit FIFO with read-side packet framing
// tracking and sticky overflow/underflow/framing error flags.
module input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic           clk,
  input logic           rst_n,
  input_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  localparam logic [1:0] FT_SINGLE = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_BODY   = 2'b10;
  localparam logic [1:0] FT_TAIL   = 2'b11;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt;
  state_t                state;
  logic                  ovf;
  logic                  udf;
  logic                  perr;

  logic                  full_i;
  logic                  empty_i;
  logic                  push;
  logic                  pop;
  logic [1:0]            pop_type;

  assign full_i   = (cnt == CNT_W'(DEPTH));
  assign empty_i  = (cnt == '0);
  // A full FIFO drops the write even when a pop happens in the same cycle.
  assign push     = bus.write && !full_i;
  assign pop      = bus.read && !empty_i;
  assign pop_type = mem[rd_ptr][DATA_WIDTH-1 -: 2];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (bus.write && full_i) ovf <= 1'b1;
      if (bus.read && empty_i) udf <= 1'b1;
    end
  end

  // Framing tracker advances only on accepted pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      perr  <= 1'b0;
    end else if (pop) begin
      case (state)
        IDLE: begin
          case (pop_type)
            FT_HEAD:   state <= IN_PKT;
            FT_SINGLE: state <= IDLE;
            default: begin
              state <= IDLE;
              perr  <= 1'b1;
            end
          endcase
        end
        IN_PKT: begin
          case (pop_type)
            FT_BODY: state <= IN_PKT;
            FT_TAIL: state <= IDLE;
            FT_HEAD: begin
              state <= IN_PKT;
              perr  <= 1'b1;
            end
            default: begin
              state <= IDLE;
              perr  <= 1'b1;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.full         = full_i;
  assign bus.empty        = empty_i;
  assign bus.count        = cnt;
  assign bus.data_out     = empty_i ? '0 : mem[rd_ptr];
  assign bus.pkt_active   = (state == IN_PKT);
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
  assign bus.protocol_err = perr;
endmodule

// File: doc/input_buffer.md
# input_buffer

Per-port flit FIFO for the NoC router; it sits directly downstream of the upstream router's output controller. It accepts flits when `write` is asserted, returns back-pressure on `full`, and presents the oldest flit first-word-fall-through to the routing/crossbar stage. It also tracks packet framing (head/body/tail) on the read side and flags overflow, underflow and framing errors.

## Interface
- `DATA_WIDTH`, 32: flit width in bits. Bits [DATA_WIDTH-1:DATA_WIDTH-2] hold the flit type:
  - 2'b01 = head
  - 2'b10 = body
  - 2'b11 = tail
  - 2'b00 = single (head+tail)
- `DEPTH`, 4: number of flit entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  one clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `write`  in  1  push request from the upstream output controller
- `data_in`  in  DATA_WIDTH  flit to push
- `full`  out  1  no free entry; fed back to the upstream output controller
- `empty`  out  1  no stored flit
- `read`  in  1  pop request from the routing/crossbar stage
- `data_out`  out  DATA_WIDTH  oldest stored flit; all-zero when `empty`
- `count`  out  $clog2(DEPTH)+1  number of stored flits, 0..DEPTH
- `pkt_active`  out  1  a multi-flit packet is partially drained (head popped, tail not yet popped)
- `overflow`  out  1  sticky: a write was attempted while full
- `underflow`  out  1  sticky: a read was attempted while empty
- `protocol_err`  out  1  sticky: a flit was popped out of framing order

## Operation
- Storage: DEPTH×DATA_WIDTH array, write pointer, read pointer, and a `count` register. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The array is not reset.
- Push is accepted iff `write && !full`. The flit is stored at the write pointer and the write pointer increments.
- Pop is accepted iff `read && !empty`. The read pointer increments.
- Accepted push and pop in the same cycle: `count` is unchanged and both pointers advance.
- A write while full is dropped: storage, pointers and `count` are unchanged and `overflow` is set. There is no pass-through when full, even if `read` is asserted in the same cycle.
- A read while empty is ignored and `underflow` is set.
- `full` = (`count` == DEPTH). `empty` = (`count` == 0). Both are decoded from the registered `count`.
- `data_out` = array[read pointer] when `!empty`, else 0.
- Framing FSM on accepted pops; states are IDLE and IN_PKT. `pkt_active` = (state == IN_PKT).
  - IDLE, pop head → IN_PKT.
  - IDLE, pop single → IDLE.
  - IDLE, pop body or tail → IDLE, set `protocol_err`.
  - IN_PKT, pop body → IN_PKT.
  - IN_PKT, pop tail → IDLE.
  - IN_PKT, pop head → IN_PKT (the new packet is taken), set `protocol_err`.
  - IN_PKT, pop single → IDLE, set `protocol_err`.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - pointers = 0, `count` = 0
  - `empty` = 1, `full` = 0, `data_out` = 0
  - state = IDLE, `pkt_active` = 0
  - `overflow` = `underflow` = `protocol_err` = 0
  - Any in-flight flits are discarded.
- Write latency is 1 cycle: a flit pushed at edge N appears on `data_out` after edge N if the FIFO was empty.
- Read: `data_out` is valid in the same cycle as `read`, because it is first-word-fall-through. The next flit appears after the popping edge.
- `full` asserts after the edge that stores the DEPTH-th flit. It deasserts after the first accepted pop edge.
- `empty` deasserts after the first accepted push edge.
- `pkt_active` and all sticky flags update on the edge of the triggering event.
- Upstream protocol: the output controller drives `write` = !`full`, so `full` is the sole flow-control path and has no combinational dependency on `write` or `read`.

## Test plan
- Reset then idle:
  - Response: `empty`=1, `full`=0, `count`=0, `data_out`=0, all flags 0.
- Fill then drain with DEPTH=4:
  - Stimulus: push 0x4000_0001, 0x8000_0002, 0x8000_0003, 0xC000_0004.
  - Response while filling: `full`=1 after the 4th edge, `count`=4.
  - Response while draining: pops return the flits in order; `pkt_active`=1 after the 1st pop and 0 after the 4th pop; `empty`=1 at the end.
- Overflow:
  - Stimulus: with the FIFO full, assert `write` with 0xDEAD_BEEF for 1 cycle.
  - Response: `overflow`=1, `count` stays 4, 0xDEAD_BEEF is never popped.
- Underflow and simultaneous push/pop:
  - Stimulus: `read` while empty, then hold push+pop for 10 cycles starting with `count`=2.
  - Response: `underflow`=1 after the empty read; `count` stays 2 throughout and the pointers wrap correctly, with data order preserved.
- Framing error:
  - Stimulus: pop a body flit 0x8000_0010 while in IDLE.
  - Response: `protocol_err`=1, `pkt_active`=0.
  - Stimulus: a single flit 0x0000_0020 popped while in IN_PKT.
  - Response: `protocol_err`=1, state returns to IDLE.
- Reset mid-packet:
  - Stimulus: with 3 flits stored and `pkt_active`=1, pulse `rst_n` low between clock edges.
  - Response: all outputs return to reset values immediately, without waiting for the clock edge.
